// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory arbiter and the memory block it fronts.
package mem_arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE  = 2'd0;
   localparam arb_state_t ST_ISSUE = 2'd1;
   localparam arb_state_t ST_WAIT  = 2'd2;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 32;

   // Index width for a vector of n requesters; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin selection: first set request bit at or above rr_ptr, wrapping.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDXW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] rr_ptr,
   output logic [IDXW-1:0] winner,
   output logic            found
);

   logic [IDXW:0]   sum;
   logic [IDXW-1:0] idx;

   // Scan NREQ positions starting at rr_ptr; the first hit wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         // rr_ptr < NREQ, so one subtraction is enough to wrap
         sum = {1'b0, rr_ptr} + (IDXW+1)'(i);
         if (sum >= (IDXW+1)'(NREQ)) begin
            sum = sum - (IDXW+1)'(NREQ);
         end
         idx = sum[IDXW-1:0];
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NREQ requesters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; pick a winner and latch its command
// ISSUE | mem_valid high for this single cycle
// WAIT  | waiting for mem_ready; timer counts toward TIMEOUT
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_wr_rd,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NREQ*WIDTH-1:0]    req_wdata,
   output logic [NREQ-1:0]          ack,
   output logic                     err,
   output logic [WIDTH-1:0]         rdata_out,
   output logic                     busy,
   output logic                     mem_valid,
   output logic                     mem_wr_rd,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic [WIDTH-1:0]         mem_wdata,
   input  logic [WIDTH-1:0]         mem_rdata,
   input  logic                     mem_ready
);

   localparam int         IDXW = idx_width(NREQ);
   // timer is compared before it increments, so the terminal count is one short
   localparam logic [7:0] TIMER_TC = 8'(TIMEOUT - 1);

   arb_state_t      state;
   logic [IDXW-1:0] rr_ptr;
   logic [IDXW-1:0] winner_q;
   logic [7:0]      timer;
   logic [IDXW-1:0] pick_idx;
   logic            pick_found;
   logic [IDXW-1:0] ptr_after;

   rr_picker #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (pick_idx),
      .found  (pick_found)
   );

   // Priority moves to the requester just after the one being served.
   always_comb begin
      ptr_after = (winner_q == IDXW'(NREQ - 1)) ? '0 : winner_q + IDXW'(1);
   end

   // Sequencer: grant, issue one memory cycle, wait for ready or timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         winner_q  <= '0;
         timer     <= '0;
         ack       <= '0;
         err       <= 1'b0;
         rdata_out <= '0;
         busy      <= 1'b0;
         mem_valid <= 1'b0;
         mem_wr_rd <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         ack <= '0;
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               mem_valid <= 1'b0;
               if (pick_found) begin
                  winner_q  <= pick_idx;
                  mem_wr_rd <= req_wr_rd[pick_idx];
                  mem_addr  <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  mem_wdata <= req_wdata[pick_idx*WIDTH +: WIDTH];
                  mem_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mem_valid <= 1'b0;
               timer     <= '0;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_ready) begin
                  ack <= NREQ'(1) << winner_q;
                  if (!mem_wr_rd) begin
                     rdata_out <= mem_rdata;
                  end
                  rr_ptr <= ptr_after;
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  timer <= timer + 8'd1;
                  if (timer == TIMER_TC) begin
                     ack       <= NREQ'(1) << winner_q;
                     err       <= 1'b1;
                     rdata_out <= '0;
                     rr_ptr    <= ptr_after;
                     busy      <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: begin
               mem_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-ready memory model and an
// expected-completion queue checked whenever ack pulses.
module tb_mem_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int DEPTH   = 32;
   localparam int AW      = 5;
   localparam int TIMEOUT = 15;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      req_wr_rd;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]      ack;
   logic                 err;
   logic [WIDTH-1:0]     rdata_out;
   logic                 busy;
   logic                 mem_valid;
   logic                 mem_wr_rd;
   logic [AW-1:0]        mem_addr;
   logic [WIDTH-1:0]     mem_wdata;
   logic [WIDTH-1:0]     mem_rdata;
   logic                 mem_ready;

   mem_arbiter #(
      .NREQ       (NREQ),
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_wr_rd (req_wr_rd),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ack       (ack),
      .err       (err),
      .rdata_out (rdata_out),
      .busy      (busy),
      .mem_valid (mem_valid),
      .mem_wr_rd (mem_wr_rd),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: ready one cycle after valid, unless never_ready is set.
   logic [WIDTH-1:0] mem [DEPTH];
   logic never_ready = 1'b0;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= 1'b0;
         if (mem_valid && !never_ready) begin
            mem_ready <= 1'b1;
            if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
            else           mem_rdata <= mem[mem_addr];
         end
      end
   end

   typedef struct {
      int          idx;
      logic        err;
      logic [7:0]  rdata;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   vectors    = 0;
   int   miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
      req_wr_rd[k]               = wr;
      req_addr[k*AW +: AW]       = a;
      req_wdata[k*WIDTH +: WIDTH] = d;
      req[k]                     = 1'b1;
   endtask

   task automatic sb_push(input int k, input logic e_err, input logic [7:0] rd, input int c);
      exp_t x;
      x.idx   = k;
      x.err   = e_err;
      x.rdata = rd;
      x.cyc   = c;
      exp_q.push_back(x);
   endtask

   task automatic wait_ack(input int k, input bit drop, input int budget);
      bit seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (ack[k]) seen = 1'b1;
      end
      if (drop) req[k] = 1'b0;
      chk($sformatf("ack%0d_arrived", k), 32'(seen), 32'd1);
   endtask

   // Scoreboard: every ack pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (rst && (ack != '0 || err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ack_vec",     32'(ack),       32'(1) << e.idx);
            chk("err",         32'(err),       32'(e.err));
            chk("rdata",       32'(rdata_out), 32'(e.rdata));
            chk("ack_cycle",   32'(cyc),       32'(e.cyc));
            chk("busy_at_ack", 32'(busy),      32'd0);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int c;

   initial begin
      req = '0; req_wr_rd = '0; req_addr = '0; req_wdata = '0;
      rst = 1'b0;
      step(2);
      chk("rst_ack",       32'(ack),       32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_rdata",     32'(rdata_out), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_wr_rd", 32'(mem_wr_rd), 32'd0);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b1;
      step(1);

      // single write then read back by requester 1
      c = cyc; drive(1, 1'b1, 5'd5, 8'hA5); sb_push(1, 1'b0, 8'h00, c + 3);
      wait_ack(1, 1'b1, 10); step(1);
      c = cyc; drive(1, 1'b0, 5'd5, 8'h00); sb_push(1, 1'b0, 8'hA5, c + 3);
      wait_ack(1, 1'b1, 10); step(1);

      // simultaneous preload writes, rr_ptr=2 so order is 2,3,0,1
      c = cyc;
      for (int k = 0; k < NREQ; k++) drive(k, 1'b1, AW'(k), 8'h10 + 8'(k));
      sb_push(2, 1'b0, 8'hA5, c + 3);
      sb_push(3, 1'b0, 8'hA5, c + 6);
      sb_push(0, 1'b0, 8'hA5, c + 9);
      sb_push(1, 1'b0, 8'hA5, c + 12);
      wait_ack(2, 1'b1, 10); wait_ack(3, 1'b1, 10);
      wait_ack(0, 1'b1, 10); wait_ack(1, 1'b1, 10);
      step(1);
      c = cyc; drive(3, 1'b1, 5'd4, 8'h14); sb_push(3, 1'b0, 8'hA5, c + 3);
      wait_ack(3, 1'b1, 10); step(1);

      // four reads with rr_ptr=0 -> 0,1,2,3, three cycles apart
      c = cyc;
      for (int k = 0; k < NREQ; k++) begin
         drive(k, 1'b0, AW'(k), 8'h00);
         sb_push(k, 1'b0, 8'h10 + 8'(k), c + 3 + 3*k);
      end
      for (int k = 0; k < NREQ; k++) wait_ack(k, 1'b1, 10);
      step(1);

      // fairness: req[0] held, req[2] pending -> 0, 2, 0
      c = cyc;
      drive(0, 1'b0, 5'd0, 8'h00); drive(2, 1'b0, 5'd2, 8'h00);
      sb_push(0, 1'b0, 8'h10, c + 3);
      sb_push(2, 1'b0, 8'h12, c + 6);
      sb_push(0, 1'b0, 8'h10, c + 9);
      wait_ack(0, 1'b0, 10); wait_ack(2, 1'b1, 10); wait_ack(0, 1'b1, 10);
      step(1);

      // command fields change during ISSUE; transaction keeps latched values
      c = cyc; drive(1, 1'b1, 5'd7, 8'h77); sb_push(1, 1'b0, 8'h10, c + 3);
      step(1);
      chk("issue_valid", 32'(mem_valid), 32'd1);
      chk("issue_addr",  32'(mem_addr),  32'd7);
      chk("issue_wdata", 32'(mem_wdata), 32'h77);
      chk("issue_wr_rd", 32'(mem_wr_rd), 32'd1);
      chk("issue_busy",  32'(busy),      32'd1);
      req_addr[1*AW +: AW] = 5'd9;
      req_wdata[1*WIDTH +: WIDTH] = 8'h99;
      req_wr_rd[1] = 1'b0;
      step(1);
      chk("wait_valid", 32'(mem_valid), 32'd0);
      chk("wait_addr",  32'(mem_addr),  32'd7);
      chk("wait_wdata", 32'(mem_wdata), 32'h77);
      chk("wait_wr_rd", 32'(mem_wr_rd), 32'd1);
      wait_ack(1, 1'b1, 10);
      chk("ack_addr", 32'(mem_addr), 32'd7);
      step(1);
      c = cyc; drive(1, 1'b0, 5'd7, 8'h00); sb_push(1, 1'b0, 8'h77, c + 3);
      wait_ack(1, 1'b1, 10); step(1);

      // timeout: ack+err 16 cycles after ISSUE, then normal service resumes
      never_ready = 1'b1;
      c = cyc; drive(3, 1'b0, 5'd1, 8'h00); sb_push(3, 1'b1, 8'h00, c + 17);
      wait_ack(3, 1'b1, 30);
      never_ready = 1'b0;
      step(1);
      c = cyc; drive(1, 1'b0, 5'd5, 8'h00); sb_push(1, 1'b0, 8'hA5, c + 3);
      wait_ack(1, 1'b1, 10); step(1);

      // asynchronous reset while in WAIT
      never_ready = 1'b1;
      drive(2, 1'b0, 5'd2, 8'h00);
      step(3);
      chk("pre_rst_busy",  32'(busy),      32'd1);
      chk("pre_rst_rdata", 32'(rdata_out), 32'hA5);
      #2 rst = 1'b0;
      #1;
      chk("arst_mem_valid", 32'(mem_valid), 32'd0);
      chk("arst_ack",       32'(ack),       32'd0);
      chk("arst_busy",      32'(busy),      32'd0);
      chk("arst_rdata",     32'(rdata_out), 32'd0);
      chk("arst_mem_addr",  32'(mem_addr),  32'd0);
      chk("arst_sb_empty",  32'(exp_q.size()), 32'd0);
      req[2] = 1'b0;
      never_ready = 1'b0;
      step(2);
      rst = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step(1);
         chk("post_rst_ack", 32'(ack), 32'd0);
      end
      // rr_ptr was 2 before reset; after reset requester 0 must win first
      c = cyc;
      drive(0, 1'b0, 5'd0, 8'h00); drive(2, 1'b0, 5'd2, 8'h00);
      sb_push(0, 1'b0, 8'h10, c + 3);
      sb_push(2, 1'b0, 8'h12, c + 6);
      wait_ack(0, 1'b1, 10); wait_ack(2, 1'b1, 10);
      step(2);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
